// File: rtl/pipeline_stage_mem.sv
// Memory-access stage: word loads/stores over a req/ack port, upstream stall while waiting,
// registered MEM/WB result, and a timeout that turns a silent memory into a bus-error retire.
module pipeline_stage_mem #(
  parameter int unsigned Timeout = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // execute-stage inputs
  input  logic        ex_wr_en_i,
  input  logic        ex_mem_en_i,
  input  logic        ex_mem_wr_i,
  input  logic [4:0]  ex_rd_sel_i,
  input  logic [31:0] ex_alu_val_i,
  input  logic [31:0] ex_store_val_i,
  // data-memory port
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  // pipeline control and writeback
  output logic        mem_stall_o,
  output logic        mem_wr_en_o,
  output logic [4:0]  mem_rd_sel_o,
  output logic [31:0] mem_wb_val_o,
  output logic        mem_misaligned_o,
  output logic        mem_bus_err_o
);

  localparam int unsigned CntW = (Timeout > 1) ? $clog2(Timeout) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Timeout - 1);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        wr_en_q, wr_en_d;
  logic [4:0]  rd_sel_q, rd_sel_d;
  logic [31:0] wb_val_q, wb_val_d;
  logic        misaligned_q, misaligned_d;
  logic        bus_err_q, bus_err_d;
  logic        stall;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wr_en_d      = wr_en_q;
    rd_sel_d     = rd_sel_q;
    wb_val_d     = wb_val_q;
    misaligned_d = 1'b0;
    bus_err_d    = 1'b0;
    stall        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!ex_mem_en_i) begin
          wr_en_d  = ex_wr_en_i;
          rd_sel_d = ex_rd_sel_i;
          wb_val_d = ex_alu_val_i;
        end else if (ex_alu_val_i[1:0] != 2'b00) begin
          // Misaligned access never reaches memory; it retires as a flagged bubble.
          wr_en_d      = 1'b0;
          misaligned_d = 1'b1;
        end else begin
          stall   = 1'b1;
          addr_d  = {ex_alu_val_i[31:2], 2'b00};
          we_d    = ex_mem_wr_i;
          wdata_d = ex_store_val_i;
          req_d   = 1'b1;
          cnt_d   = '0;
          wr_en_d = 1'b0;
          state_d = StWait;
        end
      end

      StWait: begin
        // Ack is checked first so a response on the final cycle still retires normally.
        if (dmem_ack_i) begin
          if (!we_q) begin
            wb_val_d = dmem_rdata_i;
            wr_en_d  = ex_wr_en_i;
            rd_sel_d = ex_rd_sel_i;
          end else begin
            wr_en_d = 1'b0;
          end
          req_d   = 1'b0;
          state_d = StIdle;
        end else if (cnt_q == CntMax) begin
          bus_err_d = 1'b1;
          wr_en_d   = 1'b0;
          req_d     = 1'b0;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          stall = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_en_q      <= 1'b0;
      rd_sel_q     <= '0;
      wb_val_q     <= '0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wr_en_q      <= wr_en_d;
      rd_sel_q     <= rd_sel_d;
      wb_val_q     <= wb_val_d;
      misaligned_q <= misaligned_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign dmem_req_o       = req_q;
  assign dmem_we_o        = we_q;
  assign dmem_addr_o      = addr_q;
  assign dmem_wdata_o     = wdata_q;
  assign mem_stall_o      = stall;
  assign mem_wr_en_o      = wr_en_q;
  assign mem_rd_sel_o     = rd_sel_q;
  assign mem_wb_val_o     = wb_val_q;
  assign mem_misaligned_o = misaligned_q;
  assign mem_bus_err_o    = bus_err_q;

endmodule
